// File: rtl/uart_tx_arbiter.sv
// Line-locking arbiter that lets several byte sources share one UART serializer.
// A granted requester keeps the link until it sends EOL, fills a line, or stalls too long.
module uart_tx_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter logic [7:0]  EOL       = 8'h0D,
    parameter int          MAX_LINE  = 64,
    parameter int          STALL_MAX = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   overrun
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int LINE_W  = $clog2(MAX_LINE + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     owner_r;
    logic [IDX_W-1:0]     last_owner_r;
    logic [LINE_W-1:0]    byte_cnt_r;
    logic [STALL_W-1:0]   stall_cnt_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic                 busy_r;
    logic                 overrun_r;

    logic [IDX_W-1:0]     pick_s;
    int                   rr_idx_s;
    logic                 any_valid_s;
    logic                 own_valid_s;
    logic [7:0]           own_data_s;
    logic                 xfer_s;
    logic [LINE_W-1:0]    byte_next_s;
    logic [STALL_W-1:0]   stall_next_s;
    logic                 eol_rel_s;
    logic                 line_full_s;
    logic                 stall_out_s;
    logic                 release_s;
    logic                 force_s;

    // Round-robin search from last_owner+1; walking backwards lets the nearest candidate win.
    always_comb begin
        pick_s      = '0;
        rr_idx_s    = 0;
        any_valid_s = |req_valid;
        for (int i = NUM_REQ; i >= 1; i--) begin
            rr_idx_s = (int'(last_owner_r) + i) % NUM_REQ;
            pick_s   = req_valid[rr_idx_s] ? IDX_W'(rr_idx_s) : pick_s;
        end
    end

    // Owner datapath and release decisions; the handshake passes straight through.
    always_comb begin
        own_valid_s  = req_valid[owner_r];
        own_data_s   = req_data[{owner_r, 3'b000} +: 8];
        req_ready    = '0;
        if (state_r == LOCKED) begin
            tx_valid           = own_valid_s;
            tx_data            = own_data_s;
            req_ready[owner_r] = tx_ready;
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
        end
        xfer_s       = tx_valid & tx_ready;
        byte_next_s  = byte_cnt_r + LINE_W'(1);
        stall_next_s = stall_cnt_r + STALL_W'(1);
        eol_rel_s    = xfer_s && (tx_data == EOL);
        line_full_s  = xfer_s && (byte_next_s == LINE_W'(MAX_LINE));
        // A stalled cycle has no valid byte, so it can never coincide with a transfer.
        stall_out_s  = (state_r == LOCKED) && !own_valid_s && (stall_next_s == STALL_W'(STALL_MAX));
        release_s    = eol_rel_s || line_full_s || stall_out_s;
        force_s      = !eol_rel_s && (line_full_s || stall_out_s);
    end

    // Lock FSM with counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= '0;
            last_owner_r <= IDX_W'(NUM_REQ - 1);
            byte_cnt_r   <= '0;
            stall_cnt_r  <= '0;
            grant_r      <= '0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        state_r     <= LOCKED;
                        owner_r     <= pick_s;
                        grant_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                        busy_r      <= 1'b1;
                        byte_cnt_r  <= '0;
                        stall_cnt_r <= '0;
                    end
                end
                LOCKED: begin
                    if (release_s) begin
                        state_r      <= IDLE;
                        grant_r      <= '0;
                        busy_r       <= 1'b0;
                        last_owner_r <= owner_r;
                        overrun_r    <= force_s;
                        byte_cnt_r   <= '0;
                        stall_cnt_r  <= '0;
                    end else begin
                        if (xfer_s) begin
                            byte_cnt_r <= byte_next_s;
                        end
                        stall_cnt_r <= own_valid_s ? '0 : stall_next_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = grant_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule
